// File: rtl/gpio_disp_pkg.sv
// Shared types and helpers for the GPIO/CPU display arbiter.
package gpio_disp_pkg;

  localparam int unsigned GPIO_W = 4;
  localparam int unsigned LED_W  = 10;

  typedef enum logic [1:0] {
    GPIO_OWN  = 2'd0,
    CPU_OWN   = 2'd1,
    GPIO_HOLD = 2'd2
  } disp_state_e;

  // All LEDs lit flags an out-of-range (10..15) sensor value.
  localparam logic [LED_W-1:0] LED_ALARM = '1;

  // One-hot LED for a decimal digit, alarm pattern otherwise.
  function automatic logic [LED_W-1:0] led_onehot(input logic [GPIO_W-1:0] v);
    logic [LED_W-1:0] pat;
    pat = LED_ALARM;
    if (v < GPIO_W'(LED_W)) pat = LED_W'(1) << v;
    return pat;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Two-flop synchronizer plus counter debounce; pulses change_evt_o when the
// accepted value moves.
module gpio_debounce
  import gpio_disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned W               = GPIO_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o,
  output logic         change_evt_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync1_q, sync2_q;
  logic [W-1:0]     cand_q, cand_d;
  logic [W-1:0]     stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;

  // Candidate tracking, saturating stability count, and acceptance.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    evt_d    = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if ((cnt_q == CNT_FIRE) && (cand_q != stable_q)) begin
      stable_d = cand_q;
      evt_d    = 1'b1;
    end
  end

  // Synchronizer and debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      evt_q    <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      evt_q    <= evt_d;
    end
  end

  assign stable_o     = stable_q;
  assign change_evt_o = evt_q;

endmodule

// File: rtl/gpio_display_arbiter.sv
// Arbitrates HEX0/LEDR between a debounced GPIO sensor and the CPU; a GPIO
// change preempts the CPU and holds the display for a minimum time.
module gpio_display_arbiter
  import gpio_disp_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [GPIO_W-1:0] gpio_in,
  input  logic             cpu_req,
  input  logic [GPIO_W-1:0] cpu_code,
  input  logic [LED_W-1:0] cpu_led,
  output logic [GPIO_W-1:0] disp_code,
  output logic [LED_W-1:0] led_out,
  output logic             owner,
  output logic             cpu_gnt,
  output logic             change_evt
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  disp_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [GPIO_W-1:0] stable;
  logic              evt;
  logic [GPIO_W-1:0] disp_q, disp_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              owner_q, owner_d;

  gpio_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .W               (GPIO_W)
  ) u_debounce (
    .clk          (CLOCK_50),
    .rst_n        (RESET_N),
    .raw_i        (gpio_in),
    .stable_o     (stable),
    .change_evt_o (evt)
  );

  // Ownership FSM and output selection; a GPIO event always wins.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      GPIO_OWN: begin
        if (evt) begin
          state_d = GPIO_HOLD;
          hold_d  = HOLD_LOAD;
        end else if (cpu_req) begin
          state_d = CPU_OWN;
        end
      end
      CPU_OWN: begin
        if (evt) begin
          state_d = GPIO_HOLD;
          hold_d  = HOLD_LOAD;
        end else if (!cpu_req) begin
          state_d = GPIO_OWN;
        end
      end
      GPIO_HOLD: begin
        if (evt) begin
          hold_d = HOLD_LOAD;
        end else if (hold_q == '0) begin
          state_d = cpu_req ? CPU_OWN : GPIO_OWN;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = GPIO_OWN;
    endcase
    owner_d = (state_d == CPU_OWN);
    disp_d  = owner_d ? cpu_code : stable;
    led_d   = owner_d ? cpu_led  : led_onehot(stable);
  end

  // State, hold counter and registered display outputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= GPIO_OWN;
      hold_q  <= '0;
      disp_q  <= '0;
      led_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      disp_q  <= disp_d;
      led_q   <= led_d;
      owner_q <= owner_d;
    end
  end

  assign disp_code  = disp_q;
  assign led_out    = led_q;
  assign owner      = owner_q;
  assign cpu_gnt    = owner_q;
  assign change_evt = evt;

endmodule

// File: tb/tb_gpio_display_arbiter.sv
// Directed scenarios plus randomized traffic against a run-length reference model.
module tb_gpio_display_arbiter;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 8;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [3:0] gpio_in  = '0;
  logic       cpu_req  = 1'b0;
  logic [3:0] cpu_code = '0;
  logic [9:0] cpu_led  = '0;
  logic [3:0] disp_code;
  logic [9:0] led_out;
  logic       owner, cpu_gnt, change_evt;

  gpio_display_arbiter #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .gpio_in    (gpio_in),
    .cpu_req    (cpu_req),
    .cpu_code   (cpu_code),
    .cpu_led    (cpu_led),
    .disp_code  (disp_code),
    .led_out    (led_out),
    .owner      (owner),
    .cpu_gnt    (cpu_gnt),
    .change_evt (change_evt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] exp_led(input logic [3:0] v);
    if (v <= 4'd9) return 10'd1 << v;
    return 10'h3FF;
  endfunction

  // Reference model: a value is accepted once the synchronized input has
  // shown it for DEB consecutive samples; ownership follows the event rules.
  typedef enum {M_GPIO, M_CPU, M_HOLD} own_t;
  own_t       m_mode  = M_GPIO;
  int         m_since = 0;
  int         m_run   = 1;
  logic [3:0] m_run_val = '0, m_s1 = '0, m_s2 = '0, m_stable = '0;
  logic       m_evt = 1'b0, m_evt_next = 1'b0, m_owner = 1'b0;
  logic [3:0] m_disp = '0;
  logic [9:0] m_led  = '0;

  task automatic model_step();
    if (!RESET_N) begin
      m_mode = M_GPIO; m_since = 0; m_run = 1; m_run_val = '0;
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_evt = 1'b0;
      m_owner = 1'b0; m_disp = '0; m_led = '0;
    end else begin
      if (m_evt) begin
        m_mode = M_HOLD; m_since = 1;
      end else begin
        case (m_mode)
          M_GPIO: if (cpu_req) m_mode = M_CPU;
          M_CPU:  if (!cpu_req) m_mode = M_GPIO;
          default: begin
            if (m_since >= int'(HOLD)) m_mode = cpu_req ? M_CPU : M_GPIO;
            else m_since++;
          end
        endcase
      end
      m_owner = (m_mode == M_CPU);
      m_disp  = m_owner ? cpu_code : m_stable;
      m_led   = m_owner ? cpu_led : exp_led(m_stable);
      m_evt_next = (m_run == int'(DEB)) && (m_run_val != m_stable);
      if (m_evt_next) m_stable = m_run_val;
      m_evt = m_evt_next;
      if (m_s2 == m_run_val) begin
        if (m_run <= int'(DEB)) m_run++;
      end else begin
        m_run_val = m_s2; m_run = 1;
      end
      m_s2 = m_s1;
      m_s1 = gpio_in;
    end
  endtask

  always @(posedge CLOCK_50) model_step();

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLOCK_50) begin
    if (RESET_N && chk_en) begin
      check("m_evt",   32'(change_evt), 32'(m_evt));
      check("m_owner", 32'(owner),      32'(m_owner));
      check("m_gnt",   32'(cpu_gnt),    32'(m_owner));
      check("m_disp",  32'(disp_code),  32'(m_disp));
      check("m_led",   32'(led_out),    32'(m_led));
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic wait_evt(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (change_evt) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int cnt;
    bit done;
    int left;

    // Reset values
    tick(); tick();
    check("rst_disp",  32'(disp_code),  32'd0);
    check("rst_led",   32'(led_out),    32'd0);
    check("rst_owner", 32'(owner),      32'd0);
    check("rst_gnt",   32'(cpu_gnt),    32'd0);
    check("rst_evt",   32'(change_evt), 32'd0);

    // Clean step to 3: event at edge DEB+3
    RESET_N = 1'b1; chk_en = 1'b1; gpio_in = 4'h3;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6) check("step_early", 32'(change_evt), 32'd0);
      if (e == 7) check("step_evt",   32'(change_evt), 32'd1);
      if (e == 8) begin
        check("step_disp",  32'(disp_code),  32'd3);
        check("step_led",   32'(led_out),    32'h008);
        check("step_pulse", 32'(change_evt), 32'd0);
      end
    end

    // Short glitch is ignored
    gpio_in = 4'h5; tick(); tick(); gpio_in = 4'h3;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("glitch_evt", 32'(change_evt), 32'd0);
    end
    check("glitch_disp", 32'(disp_code), 32'd3);

    // CPU takes the display
    cpu_req = 1'b1; cpu_code = 4'h9; cpu_led = 10'h155;
    tick();
    check("cpu_owner", 32'(owner),     32'd1);
    check("cpu_gnt",   32'(cpu_gnt),   32'd1);
    check("cpu_disp",  32'(disp_code), 32'd9);
    check("cpu_led",   32'(led_out),   32'h155);

    // GPIO preempts with alarm value, holds HOLD cycles, CPU resumes
    gpio_in = 4'hC;
    wait_evt("pre_evt");
    for (int i = 0; i < int'(HOLD); i++) begin
      tick();
      check("hold_owner", 32'(owner),     32'd0);
      check("hold_led",   32'(led_out),   32'h3FF);
      check("hold_disp",  32'(disp_code), 32'hC);
    end
    tick();
    check("resume_owner", 32'(owner),     32'd1);
    check("resume_disp",  32'(disp_code), 32'd9);

    // Second change during hold reloads the hold counter
    gpio_in = 4'h2;
    for (int i = 0; i < 6; i++) tick();
    gpio_in = 4'h7;
    wait_evt("reload_evt1");
    wait_evt("reload_evt2");
    cnt = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (owner) done = 1'b1;
      else cnt++;
    end
    check("reload_len",  32'(cnt),       32'(HOLD));
    check("reload_back", 32'(disp_code), 32'd9);

    // Reset mid-hold clears everything at once; value must requalify
    cpu_req = 1'b0; gpio_in = 4'h9;
    wait_evt("rh_evt");
    tick(); tick();
    @(posedge CLOCK_50);
    #2 RESET_N = 1'b0;
    #1;
    check("arst_disp",  32'(disp_code),  32'd0);
    check("arst_led",   32'(led_out),    32'd0);
    check("arst_owner", 32'(owner),      32'd0);
    check("arst_gnt",   32'(cpu_gnt),    32'd0);
    check("arst_evt",   32'(change_evt), 32'd0);
    @(negedge CLOCK_50);
    tick(); tick();
    RESET_N = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) check("requal_early", 32'(change_evt), 32'd0);
      if (e == 7) check("requal_evt",   32'(change_evt), 32'd1);
    end

    // Randomized traffic checked against the model
    left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        gpio_in = 4'($urandom_range(0, 15));
        left    = int'($urandom_range(1, 10));
      end
      left--;
      if ($urandom_range(0, 19) == 0) cpu_req = ~cpu_req;
      cpu_code = 4'($urandom);
      cpu_led  = 10'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_display_arbiter.md
GPIO_DISPLAY_ARBITER -- requirements
Module: gpio_display_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable cycles required to accept a GPIO value (10 ms at 50 MHz).
REQ-002 Parameter HOLD_CYCLES, default 50000000, is the minimum number of cycles GPIO keeps the display after preempting the CPU (1 s).
REQ-003 Port CLOCK_50 input 1: the single clock; all logic is on its rising edge.
REQ-004 Port RESET_N input 1: asynchronous, active-low reset.
REQ-005 Port gpio_in input 4: raw asynchronous sensor nibble from GPIO[3:0].
REQ-006 Port cpu_req input 1: processor PIO requests ownership of the display.
REQ-007 Port cpu_code input 4: the digit the processor wants shown.
REQ-008 Port cpu_led input 10: the LED pattern the processor wants shown.
REQ-009 Port disp_code output 4: the registered digit, fed to the bcd_7segment decoder for HEX0.
REQ-010 Port led_out output 10: registered LEDR drive.
REQ-011 Port owner output 1: 0 when GPIO owns the display, 1 when the CPU owns it.
REQ-012 Port cpu_gnt output 1: high while the CPU owns the display; equals owner.
REQ-013 Port change_evt output 1: one-cycle pulse when the debounced GPIO value changes.

Function
REQ-014 gpio_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Debounce: a candidate register and a counter; when sync != candidate, candidate <= sync and counter <= 0; otherwise the counter increments, saturating at DEBOUNCE_CYCLES.
REQ-016 When counter == DEBOUNCE_CYCLES-1 and candidate != stable, stable <= candidate and change_evt SHALL pulse for exactly one cycle, coincident with the stable update.
REQ-017 Latency: a clean gpio_in step SHALL produce change_evt DEBOUNCE_CYCLES+3 clock edges after the first edge that samples the new value; any glitch shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-018 The FSM has three states: GPIO_OWN, CPU_OWN and GPIO_HOLD.
REQ-019 GPIO_OWN: change_evt -> GPIO_HOLD; else cpu_req -> CPU_OWN.
REQ-020 CPU_OWN: change_evt -> GPIO_HOLD (GPIO preempts); else !cpu_req -> GPIO_OWN.
REQ-021 GPIO_HOLD: the hold counter loads HOLD_CYCLES-1 on entry and on every change_evt while in this state, and decrements otherwise.
REQ-022 GPIO_HOLD exit: at hold counter == 0 -> CPU_OWN if cpu_req, else GPIO_OWN.
REQ-023 Simultaneous change_evt and cpu_req in any state SHALL resolve to GPIO_HOLD.
REQ-024 owner and cpu_gnt SHALL be 1 only in CPU_OWN, registered from the state, and change one cycle after the transition condition.
REQ-025 disp_code SHALL be registered: cpu_code when the next state is CPU_OWN, else stable.
REQ-026 led_out SHALL be registered: cpu_led when the next state is CPU_OWN; otherwise, for stable value v in 0..9, a one-hot pattern with bit v set; for v in 10..15, all ones (alarm).
REQ-027 cpu_code and cpu_led SHALL be sampled every cycle while in CPU_OWN, with no additional latency beyond the output register.

Reset
REQ-028 While RESET_N is low: state = GPIO_OWN; sync flops, candidate, stable and both counters = 0; disp_code = 0, led_out = 0, owner = 0, cpu_gnt = 0, change_evt = 0.
REQ-029 Reset assertion mid-hold or mid-debounce SHALL abandon the operation immediately; after release, a GPIO value must requalify for the full DEBOUNCE_CYCLES.
REQ-030 Reset release SHALL be synchronized externally; no internal reset synchronizer is required.

Structure
REQ-031 Package gpio_disp_pkg SHALL hold the state enum, the LED alarm constant (all ones) and the one-hot LED mapping function.
REQ-032 Sub-module gpio_debounce SHALL contain the synchronizer, the debounce logic and change_evt generation, with one instance for the 4-bit vector.
REQ-033 Counter widths SHALL be derived from the parameters with $clog2.

Verification
REQ-034 Run the bench with DEBOUNCE_CYCLES=4 and HOLD_CYCLES=8.
REQ-035 Reset, then gpio_in=4'h3 held -> change_evt at edge 7; disp_code=3 and led_out=10'b0000001000 one cycle later.
REQ-036 gpio_in pulses 3->5->3 for 2 cycles -> no change_evt; disp_code stays 3.
REQ-037 cpu_req=1, cpu_code=9, cpu_led=10'h155 -> owner=1 next cycle; disp_code=9, led_out=10'h155.
REQ-038 In CPU_OWN, gpio_in=4'hC -> GPIO_HOLD; led_out=10'h3FF and disp_code=C for 8 cycles, then CPU_OWN with owner=1 because cpu_req is still 1.
REQ-039 In GPIO_HOLD, a second GPIO change at hold count 2 -> hold reloads; total hold is at least 8 cycles after the second change_evt.
REQ-040 Assert RESET_N low during GPIO_HOLD -> all outputs 0 and state GPIO_OWN within the same cycle.
